// File: rtl/instr_encoder_pkg.sv
// ISA helpers shared with the decode controller: AluOp codes, MIPS opcode/func fields,
// request legality and the instruction-word encoder.
package alu_isa_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_NOR = 4'b0100,
        ALU_XOR = 4'b0101,
        ALU_SLT = 4'b0110,
        ALU_SGT = 4'b0111,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001,
        ALU_NOP = 4'b1111
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_NOR = 6'b100111;
    localparam logic [5:0] FUNC_XOR = 6'b100110;
    localparam logic [5:0] FUNC_SLT = 6'b101010;
    localparam logic [5:0] FUNC_SGT = 6'b110000;
    localparam logic [5:0] FUNC_SLL = 6'b000000;
    localparam logic [5:0] FUNC_SRL = 6'b000010;

    // Ops without an immediate counterpart are legal only in R-type form.
    function automatic logic is_legal(input logic [3:0] aluop, input logic imm_mode);
        logic ok;
        case (aluop)
            ALU_ADD, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_NOP: ok = 1'b1;
            ALU_SUB, ALU_NOR, ALU_SGT, ALU_SLL, ALU_SRL:        ok = !imm_mode;
            default:                                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] encode(input logic [3:0] aluop, input logic imm_mode,
                                           input logic [4:0] rd, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] shamt,
                                           input logic [15:0] imm);
        logic [5:0]  op;
        logic [5:0]  func;
        logic        is_shift;
        logic [31:0] word;
        op       = OP_RTYPE;
        func     = FUNC_ADD;
        is_shift = (aluop == ALU_SLL) || (aluop == ALU_SRL);
        case (aluop)
            ALU_ADD: begin op = OP_ADDI; func = FUNC_ADD; end
            ALU_SUB: func = FUNC_SUB;
            ALU_AND: begin op = OP_ANDI; func = FUNC_AND; end
            ALU_OR:  begin op = OP_ORI;  func = FUNC_OR;  end
            ALU_NOR: func = FUNC_NOR;
            ALU_XOR: begin op = OP_XORI; func = FUNC_XOR; end
            ALU_SLT: begin op = OP_SLTI; func = FUNC_SLT; end
            ALU_SGT: func = FUNC_SGT;
            ALU_SLL: func = FUNC_SLL;
            ALU_SRL: func = FUNC_SRL;
            default: ;
        endcase
        if (aluop == ALU_NOP)
            word = '0;
        else if (imm_mode)
            word = {op, rs, rd, imm};
        else
            word = {OP_RTYPE, (is_shift ? 5'd0 : rs), rt, rd, (is_shift ? shamt : 5'd0), func};
        return word;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-stream handshake bundle for instr_encoder.
// ENC_PARITY_EN adds the out_parity signal.
interface instr_encoder_if #(parameter int ADDR_W = 10);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_aluop;
    logic              in_imm_mode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
`ifdef ENC_PARITY_EN
    logic              out_parity;

    modport master (output in_valid, in_aluop, in_imm_mode, in_rd, in_rs, in_rt, in_shamt, in_imm,
                    output out_ready, input in_ready, out_valid, out_instr, out_addr, out_parity);
    modport slave  (input in_valid, in_aluop, in_imm_mode, in_rd, in_rs, in_rt, in_shamt, in_imm,
                    input out_ready, output in_ready, out_valid, out_instr, out_addr, out_parity);
`else
    modport master (output in_valid, in_aluop, in_imm_mode, in_rd, in_rs, in_rt, in_shamt, in_imm,
                    output out_ready, input in_ready, out_valid, out_instr, out_addr);
    modport slave  (input in_valid, in_aluop, in_imm_mode, in_rd, in_rs, in_rt, in_shamt, in_imm,
                    input out_ready, output in_ready, out_valid, out_instr, out_addr);
`endif
endinterface

// File: rtl/instr_encoder_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty flags and sync active-high reset.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // Flags only change when occupancy does; simultaneous push/pop leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop) begin
                empty <= 1'b0;
                full  <= ((wr_ptr + PTR_ONE) == rd_ptr);
            end else if (do_pop && !do_push) begin
                full  <= 1'b0;
                empty <= ((rd_ptr + PTR_ONE) == wr_ptr);
            end
        end
    end
endmodule

// File: rtl/instr_encoder.sv
// Encodes AluOp requests into MIPS words, queues them and streams them with byte addresses.
// Optional ENC_PARITY_EN: stores ^instr alongside each word and drives out_parity.
module instr_encoder
    import alu_isa_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter int                ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic           clk,
    input  logic           rst,
    instr_encoder_if.slave bus,
    output logic           err_illegal
);
`ifdef ENC_PARITY_EN
    localparam int FIFO_W = 33;
`else
    localparam int FIFO_W = 32;
`endif

    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              legal;
    logic              push;
    logic              pop;
    logic [31:0]       word;
    logic [FIFO_W-1:0] fifo_wdata;
    logic [FIFO_W-1:0] fifo_rdata;
    logic [ADDR_W-1:0] addr_q;

    assign legal  = is_legal(bus.in_aluop, bus.in_imm_mode);
    assign word   = encode(bus.in_aluop, bus.in_imm_mode, bus.in_rd, bus.in_rs,
                           bus.in_rt, bus.in_shamt, bus.in_imm);
    // Illegal requests still complete the handshake; they just never reach the FIFO.
    assign accept = bus.in_valid && !fifo_full;
    assign push   = accept && legal;
    assign pop    = !fifo_empty && bus.out_ready;

`ifdef ENC_PARITY_EN
    assign fifo_wdata     = {^word, word};
    assign bus.out_parity = fifo_empty ? 1'b0 : fifo_rdata[32];
`else
    assign fifo_wdata     = word;
`endif

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.in_ready  = !fifo_full;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_instr = fifo_empty ? 32'h0 : fifo_rdata[31:0];
    assign bus.out_addr  = addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= BASE_ADDR;
            err_illegal <= 1'b0;
        end else begin
            if (pop)
                addr_q <= addr_q + ADDR_W'(4);
            if (accept && !legal)
                err_illegal <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, illegal requests, backpressure, address wrap, reset.
module tb_instr_encoder;
    import alu_isa_pkg::*;

    logic clk;
    logic rst;
    logic err_illegal;
    logic err_illegal4;
    int   n_checks = 0;
    int   n_pass   = 0;

    instr_encoder_if #(.ADDR_W(10)) bus ();
    instr_encoder_if #(.ADDR_W(4))  bus4 ();

    instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(10), .BASE_ADDR(10'h000)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .err_illegal (err_illegal)
    );

    instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(4), .BASE_ADDR(4'h0)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus4),
        .err_illegal (err_illegal4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic imm_mode, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] shamt,
                        input logic [15:0] imm);
        int waited = 0;
        bus.in_aluop    = op;
        bus.in_imm_mode = imm_mode;
        bus.in_rd       = rd;
        bus.in_rs       = rs;
        bus.in_rt       = rt;
        bus.in_shamt    = shamt;
        bus.in_imm      = imm;
        bus.in_valid    = 1'b1;
        while (!bus.in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("send_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    logic [31:0] add_words [5] = '{32'h00220820, 32'h00221020, 32'h00221820,
                                   32'h00222020, 32'h00222820};
    logic [31:0] ori_words [5] = '{32'h342000FF, 32'h342100FF, 32'h342200FF,
                                   32'h342300FF, 32'h342400FF};
    logic [3:0]  wrap_addrs [5] = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h0};

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;  bus.in_aluop = '0; bus.in_imm_mode = 1'b0;
        bus.in_rd = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_shamt = '0; bus.in_imm = '0;
        bus.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_aluop = ALU_OR; bus4.in_imm_mode = 1'b1;
        bus4.in_rd = '0; bus4.in_rs = 5'd1; bus4.in_rt = '0; bus4.in_shamt = '0;
        bus4.in_imm = 16'h00FF; bus4.out_ready = 1'b1;

        do_reset();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_out_addr",  bus.out_addr, 10'h000);
        check("rst_err",       err_illegal, 1'b0);
        check("rst_in_ready",  bus.in_ready, 1'b1);
`ifdef ENC_PARITY_EN
        check("rst_parity",    bus.out_parity, 1'b0);
`endif

        // ADD rd=3 rs=1 rt=2 appears one cycle after accept
        send(ALU_ADD, 1'b0, 5'd3, 5'd1, 5'd2, 5'd0, 16'h0);
        check("add_valid", bus.out_valid, 1'b1);
        check("add_instr", bus.out_instr, 32'h00221820);
        check("add_addr",  bus.out_addr, 10'h000);
`ifdef ENC_PARITY_EN
        check("add_parity", bus.out_parity, 1'b1);
`endif
        tick();
        check("add_popped", bus.out_valid, 1'b0);
        check("add_addr_inc", bus.out_addr, 10'h004);

        // ADDI then SLL, streaming with simultaneous push and pop
        do_reset();
        send(ALU_ADD, 1'b1, 5'd5, 5'd0, 5'd0, 5'd0, 16'h0010);
        check("addi_instr", bus.out_instr, 32'h20050010);
        check("addi_addr",  bus.out_addr, 10'h000);
        send(ALU_SLL, 1'b0, 5'd4, 5'd7, 5'd2, 5'd3, 16'h0);
        check("sll_instr", bus.out_instr, 32'h000220C0);
        check("sll_addr",  bus.out_addr, 10'h004);
        send(ALU_XOR, 1'b0, 5'd7, 5'd8, 5'd9, 5'd5, 16'h0);
        check("xor_instr", bus.out_instr, 32'h01093826);
        send(ALU_SRL, 1'b0, 5'd1, 5'd5, 5'd2, 5'd31, 16'h0);
        check("srl_instr", bus.out_instr, 32'h00020FC2);
        send(ALU_SLT, 1'b1, 5'd2, 5'd3, 5'd0, 5'd0, 16'hFFFF);
        check("slti_instr", bus.out_instr, 32'h2862FFFF);
        send(ALU_NOP, 1'b1, 5'd9, 5'd9, 5'd9, 5'd9, 16'h1234);
        check("nop_valid", bus.out_valid, 1'b1);
        check("nop_instr", bus.out_instr, 32'h0);
        check("nop_addr",  bus.out_addr, 10'h014);
        tick();
        check("stream_drained", bus.out_valid, 1'b0);

        // Illegal requests are consumed, not pushed, and latch the error
        do_reset();
        send(ALU_SUB, 1'b1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0001);
        check("ill_sub_valid", bus.out_valid, 1'b0);
        check("ill_sub_err",   err_illegal, 1'b1);
        send(4'b1100, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        check("ill_op_valid", bus.out_valid, 1'b0);
        check("ill_op_ready", bus.in_ready, 1'b1);
        tick();
        tick();
        check("ill_err_held", err_illegal, 1'b1);

        // Backpressure: fill the FIFO, then drain in order
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(ALU_ADD, 1'b0, 5'(i + 1), 5'd1, 5'd2, 5'd0, 16'h0);
        check("full_in_ready", bus.in_ready, 1'b0);
        bus.in_rd    = 5'd5;
        bus.in_valid = 1'b1;
        tick();
        tick();
        check("full_hold_ready", bus.in_ready, 1'b0);
        check("full_hold_instr", bus.out_instr, add_words[0]);
        check("full_hold_addr",  bus.out_addr, 10'h000);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("drain_instr%0d", i), bus.out_instr, add_words[i]);
            check($sformatf("drain_addr%0d", i),  bus.out_addr, 10'(4 * i));
            tick();
            if (i == 1)
                bus.in_valid = 1'b0;
        end
        check("drain_empty", bus.out_valid, 1'b0);

        // Address wrap on the 4-bit instance
        for (int i = 0; i < 5; i++) begin
            bus4.in_rd    = 5'(i);
            bus4.in_valid = 1'b1;
            tick();
            check($sformatf("wrap_addr%0d", i),  bus4.out_addr, wrap_addrs[i]);
            check($sformatf("wrap_instr%0d", i), bus4.out_instr, ori_words[i]);
            check($sformatf("wrap_ready%0d", i), bus4.in_ready, 1'b1);
        end
        bus4.in_valid = 1'b0;
        tick();
        check("wrap_drained", bus4.out_valid, 1'b0);
        check("wrap_err", err_illegal4, 1'b0);

        // Reset with entries queued discards them
        do_reset();
        bus.out_ready = 1'b1;
        send(ALU_ADD, 1'b0, 5'd3, 5'd1, 5'd2, 5'd0, 16'h0);
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(ALU_ADD, 1'b0, 5'(i + 1), 5'd1, 5'd2, 5'd0, 16'h0);
        send(4'b1110, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        check("pre_rst_valid", bus.out_valid, 1'b1);
        check("pre_rst_addr",  bus.out_addr, 10'h004);
        check("pre_rst_err",   err_illegal, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_addr",  bus.out_addr, 10'h000);
        check("mid_rst_err",   err_illegal, 1'b0);
        check("mid_rst_instr", bus.out_instr, 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", bus.in_ready, 1'b1);
        check("post_rst_valid", bus.out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
